// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame controller that owns the framebuffer write port.
// Each frame runs in a fixed order: clear the back buffer to CLEAR_COLOR, hand the
// write port to sprite_driver, then issue a buffer swap on the next vsync rising edge.
//
// Ports:
//   clock, reset          pixel clock; asynchronous active-high reset
//   vsync                 global vsync (synchronous to clock); frame boundary = rising edge
//   spr_start (out)       one-cycle pulse: sprite_driver may begin drawing
//   spr_done              one-cycle pulse: sprite_driver finished the frame
//   spr_addr/data/en      sprite write port, forwarded only while drawing
//   wr_addr/data/en (out) registered framebuffer write port
//   fb_swap (out)         one-cycle pulse: swap front/back buffers
//   fb_resetting (out)    high while the clear sweep is in progress
//   frame_count (out)     swaps issued, wrapping
//   overrun_count (out)   vsync edges missed because the frame was not ready, saturating
module frame_sequencer #(
    parameter int unsigned ADDR_W      = 19,
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned PIXELS      = 307200,
    parameter int unsigned CLEAR_COLOR = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              vsync,
    output logic              spr_start,
    input  logic              spr_done,
    input  logic [ADDR_W-1:0] spr_addr,
    input  logic [DATA_W-1:0] spr_data,
    input  logic              spr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic              fb_swap,
    output logic              fb_resetting,
    output logic [15:0]       frame_count,
    output logic [7:0]        overrun_count
);

    typedef enum logic [1:0] {StClear, StDraw, StReady, StSwap} state_e;

    localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(PIXELS - 1);
    localparam logic [DATA_W-1:0] ClearData = DATA_W'(CLEAR_COLOR);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              vsync_q;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              spr_start_q, spr_start_d;
    logic              fb_swap_q, fb_swap_d;
    logic              fb_resetting_q, fb_resetting_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic [7:0]        overrun_count_q, overrun_count_d;
    logic              vsync_edge;
    logic              overrun_hit;

    assign vsync_edge = vsync & ~vsync_q;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        wr_addr_d       = wr_addr_q;
        wr_data_d       = wr_data_q;
        wr_en_d         = 1'b0;
        spr_start_d     = 1'b0;
        overrun_hit     = 1'b0;

        unique case (state_q)
            StClear: begin
                wr_en_d     = 1'b1;
                wr_addr_d   = cnt_q;
                wr_data_d   = ClearData;
                overrun_hit = vsync_edge;
                if (cnt_q == LastAddr) begin
                    cnt_d   = '0;
                    state_d = StDraw;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDraw: begin
                wr_en_d   = spr_en;
                wr_addr_d = spr_addr;
                wr_data_d = spr_data;
                // fb_resetting_q is still high only in the first DRAW cycle, which makes it
                // the start marker; a spr_done before spr_start has gone out is spurious.
                spr_start_d = fb_resetting_q;
                if (spr_done && !fb_resetting_q) begin
                    state_d = vsync_edge ? StSwap : StReady;
                end else begin
                    overrun_hit = vsync_edge;
                end
            end
            StReady: begin
                if (vsync_edge) begin
                    state_d = StSwap;
                end
            end
            StSwap: begin
                state_d = StClear;
            end
        endcase

        fb_swap_d      = (state_d == StSwap);
        frame_count_d  = frame_count_q + {15'd0, fb_swap_d};
        // Stay high through the last clear write, and rise again as soon as CLEAR is entered.
        fb_resetting_d = (state_q == StClear) || (state_d == StClear);

        overrun_count_d = overrun_count_q;
        if (overrun_hit && (overrun_count_q != 8'hFF)) begin
            overrun_count_d = overrun_count_q + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= StClear;
            cnt_q           <= '0;
            vsync_q         <= 1'b0;
            wr_addr_q       <= '0;
            wr_data_q       <= '0;
            wr_en_q         <= 1'b0;
            spr_start_q     <= 1'b0;
            fb_swap_q       <= 1'b0;
            fb_resetting_q  <= 1'b1;
            frame_count_q   <= '0;
            overrun_count_q <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            vsync_q         <= vsync;
            wr_addr_q       <= wr_addr_d;
            wr_data_q       <= wr_data_d;
            wr_en_q         <= wr_en_d;
            spr_start_q     <= spr_start_d;
            fb_swap_q       <= fb_swap_d;
            fb_resetting_q  <= fb_resetting_d;
            frame_count_q   <= frame_count_d;
            overrun_count_q <= overrun_count_d;
        end
    end

    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign wr_en         = wr_en_q;
    assign spr_start     = spr_start_q;
    assign fb_swap       = fb_swap_q;
    assign fb_resetting  = fb_resetting_q;
    assign frame_count   = frame_count_q;
    assign overrun_count = overrun_count_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with a small framebuffer (16 pixels).
// Expected framebuffer writes go into a queue when the stimulus that causes them is
// applied; a negedge monitor pops and compares every write the DUT makes.
module tb_frame_sequencer;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned PIXELS = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              vsync = 1'b0;
    logic              spr_start;
    logic              spr_done = 1'b0;
    logic [ADDR_W-1:0] spr_addr = '0;
    logic [DATA_W-1:0] spr_data = '0;
    logic              spr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic              fb_swap;
    logic              fb_resetting;
    logic [15:0]       frame_count;
    logic [7:0]        overrun_count;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [ADDR_W+DATA_W-1:0] exp_w;

    frame_sequencer #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .PIXELS     (PIXELS),
        .CLEAR_COLOR(0)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .vsync        (vsync),
        .spr_start    (spr_start),
        .spr_done     (spr_done),
        .spr_addr     (spr_addr),
        .spr_data     (spr_data),
        .spr_en       (spr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .fb_swap      (fb_swap),
        .fb_resetting (fb_resetting),
        .frame_count  (frame_count),
        .overrun_count(overrun_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_clear();
        for (int i = 0; i < PIXELS; i++) begin
            exp_q.push_back({ADDR_W'(i), DATA_W'(0)});
        end
    endtask

    task automatic nxt();
        @(negedge clock);
    endtask

    // Write scoreboard
    always @(negedge clock) begin
        if (wr_en === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_write: observed addr %0h data %0h expected no write",
                       wr_addr, wr_data);
            end
            if (exp_q.size() != 0) begin
                exp_w = exp_q.pop_front();
                check("write", 32'({wr_addr, wr_data}), 32'(exp_w));
            end
        end
    end

    initial begin
        // Reset values
        nxt();
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_spr_start", 32'(spr_start), 32'd0);
        check("rst_fb_swap", 32'(fb_swap), 32'd0);
        check("rst_fb_resetting", 32'(fb_resetting), 32'd1);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_overrun", 32'(overrun_count), 32'd0);

        // 1: first clear sweep
        reset = 1'b0;
        push_clear();
        for (int i = 0; i < PIXELS; i++) begin
            nxt();
            check("clr1_en", 32'(wr_en), 32'd1);
            check("clr1_resetting", 32'(fb_resetting), 32'd1);
            check("clr1_no_start", 32'(spr_start), 32'd0);
        end
        nxt();
        check("start1", 32'(spr_start), 32'd1);
        check("start1_resetting", 32'(fb_resetting), 32'd0);
        check("start1_no_write", 32'(wr_en), 32'd0);

        // 2: sprite write passes through with one cycle of latency
        spr_en   = 1'b1;
        spr_addr = 8'd5;
        spr_data = 4'hA;
        exp_q.push_back({8'd5, 4'hA});
        nxt();
        check("start1_one_cycle", 32'(spr_start), 32'd0);
        check("spr_write_en", 32'(wr_en), 32'd1);
        spr_en = 1'b0;
        nxt();
        check("spr_write_end", 32'(wr_en), 32'd0);

        // 3: spr_done, vsync 10 cycles later
        spr_done = 1'b1;
        nxt();
        spr_done = 1'b0;
        repeat (9) begin
            nxt();
            check("ready_no_swap", 32'(fb_swap), 32'd0);
        end
        vsync = 1'b1;
        nxt();
        check("swap1", 32'(fb_swap), 32'd1);
        check("swap1_frames", 32'(frame_count), 32'd1);
        check("swap1_no_start", 32'(spr_start), 32'd0);
        push_clear();
        nxt();
        check("swap1_one_cycle", 32'(fb_swap), 32'd0);
        check("swap1_resetting", 32'(fb_resetting), 32'd1);
        check("swap1_gap", 32'(wr_en), 32'd0);
        vsync = 1'b0;

        // 4: vsync during clear (at address 7) is an overrun
        for (int i = 0; i < PIXELS; i++) begin
            nxt();
            check("clr2_en", 32'(wr_en), 32'd1);
            check("clr2_no_swap", 32'(fb_swap), 32'd0);
            if (i == 7) vsync = 1'b1;
        end
        nxt();
        check("start2", 32'(spr_start), 32'd1);
        check("overrun1", 32'(overrun_count), 32'd1);
        check("overrun1_frames", 32'(frame_count), 32'd1);
        vsync    = 1'b0;
        spr_done = 1'b1;
        nxt();
        spr_done = 1'b0;
        repeat (2) begin
            nxt();
            check("ready2_no_swap", 32'(fb_swap), 32'd0);
        end
        vsync = 1'b1;
        nxt();
        check("swap2", 32'(fb_swap), 32'd1);
        check("swap2_frames", 32'(frame_count), 32'd2);
        check("swap2_overrun", 32'(overrun_count), 32'd1);
        push_clear();
        nxt();
        vsync = 1'b0;

        // 5: spr_done coincident with a vsync edge swaps directly
        for (int i = 0; i < PIXELS; i++) begin
            nxt();
            check("clr3_en", 32'(wr_en), 32'd1);
        end
        nxt();
        check("start3", 32'(spr_start), 32'd1);
        spr_done = 1'b1;
        vsync    = 1'b1;
        nxt();
        spr_done = 1'b0;
        check("swap3_direct", 32'(fb_swap), 32'd1);
        check("swap3_frames", 32'(frame_count), 32'd3);
        check("swap3_overrun", 32'(overrun_count), 32'd1);
        push_clear();
        nxt();
        vsync = 1'b0;

        // 6: reset at clear address 9
        for (int i = 0; i < 10; i++) begin
            nxt();
            check("clr4_en", 32'(wr_en), 32'd1);
        end
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_wr_en", 32'(wr_en), 32'd0);
        check("async_rst_frames", 32'(frame_count), 32'd0);
        check("async_rst_overrun", 32'(overrun_count), 32'd0);
        check("async_rst_resetting", 32'(fb_resetting), 32'd1);
        exp_q.delete();
        nxt();
        nxt();
        reset = 1'b0;
        push_clear();
        for (int i = 0; i < PIXELS; i++) begin
            nxt();
            check("clr5_en", 32'(wr_en), 32'd1);
        end
        nxt();
        check("start5", 32'(spr_start), 32'd1);
        check("start5_frames", 32'(frame_count), 32'd0);
        check("start5_overrun", 32'(overrun_count), 32'd0);

        // 300 missed vsyncs in DRAW saturate the overrun counter
        for (int k = 1; k <= 300; k++) begin
            vsync = 1'b1;
            nxt();
            if (k == 254) check("overrun_254", 32'(overrun_count), 32'd254);
            vsync = 1'b0;
            nxt();
        end
        check("overrun_sat", 32'(overrun_count), 32'd255);
        check("overrun_sat_frames", 32'(frame_count), 32'd0);
        check("overrun_sat_swap", 32'(fb_swap), 32'd0);
        check("writes_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
